// File: rtl/pointwise_conv.sv
// pointwise_conv: 1x1 convolution layer engine, one MAC per cycle, bias add, ReLU and 15-bit saturation.
module pointwise_conv #(
  parameter int IN_CHANNELS  = 192,
  parameter int OUT_CHANNELS = 64,
  parameter int HEIGHT       = 28,
  parameter int WIDTH        = 32,
  parameter int SHIFT        = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               in_en,
  output logic [17:0]        in_addr,
  input  logic signed [15:0] in_data,
  output logic               w_en,
  output logic [13:0]        w_addr,
  input  logic signed [7:0]  w_data,
  output logic               b_en,
  output logic [5:0]         b_addr,
  input  logic signed [15:0] b_data,
  output logic               out_we,
  output logic [15:0]        out_addr,
  output logic [15:0]        out_data
);
  localparam int NPIX = HEIGHT * WIDTH;
  localparam int ICW  = IN_CHANNELS > 1 ? $clog2(IN_CHANNELS) : 1;
  localparam int PW   = NPIX > 1 ? $clog2(NPIX) : 1;
  localparam int OCW  = OUT_CHANNELS > 1 ? $clog2(OUT_CHANNELS) : 1;
  typedef enum logic [2:0] {IDLE, MAC, DRAIN, WRITE, DONE} state_t;
  state_t st, ns;
  logic [ICW-1:0] ic, nic;
  logic [PW-1:0] pix, npix;
  logic [OCW-1:0] oc, noc;
  logic last_ic, last_pix, last_oc, b_pend;
  logic signed [31:0] acc, prod, acc_f, sum;
  logic signed [15:0] bias_r, bias;
  logic [15:0] clamp_v;
  assign last_ic  = ic == ICW'(IN_CHANNELS - 1);
  assign last_pix = pix == PW'(NPIX - 1);
  assign last_oc  = oc == OCW'(OUT_CHANNELS - 1);
  assign prod     = 32'(in_data) * 32'(w_data);
  assign acc_f    = acc + prod;
  // bias read lands one cycle after b_en; with a single input channel that is the DRAIN cycle itself
  assign bias     = b_pend ? b_data : bias_r;
  assign sum      = (acc_f >>> SHIFT) + 32'(bias);
  assign clamp_v  = sum < 0 ? 16'd0 : sum > 32767 ? 16'h7fff : sum[15:0];
  always_comb begin
    ns   = st;
    nic  = ic;
    npix = pix;
    noc  = oc;
    case (st)
      IDLE: if (start) begin
        ns   = MAC;
        nic  = '0;
        npix = '0;
        noc  = '0;
      end
      MAC: if (last_ic) ns = DRAIN; else nic = ic + 1'b1;
      DRAIN: ns = WRITE;
      WRITE: begin
        ns   = last_pix && last_oc ? DONE : MAC;
        nic  = '0;
        npix = last_pix ? '0 : pix + 1'b1;
        noc  = last_pix ? oc + 1'b1 : oc;
      end
      default: ns = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      ic       <= '0;
      pix      <= '0;
      oc       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      in_en    <= 1'b0;
      w_en     <= 1'b0;
      b_en     <= 1'b0;
      in_addr  <= '0;
      w_addr   <= '0;
      b_addr   <= '0;
      b_pend   <= 1'b0;
      bias_r   <= '0;
      acc      <= '0;
      out_we   <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
    end else begin
      st       <= ns;
      ic       <= nic;
      pix      <= npix;
      oc       <= noc;
      busy     <= ns != IDLE;
      done     <= ns == DONE;
      in_en    <= ns == MAC;
      w_en     <= ns == MAC;
      b_en     <= ns == MAC && nic == '0;
      in_addr  <= ns == MAC ? 18'(int'(nic) * NPIX + int'(npix)) : '0;
      w_addr   <= ns == MAC ? 14'(int'(noc) * IN_CHANNELS + int'(nic)) : '0;
      b_addr   <= ns == MAC && nic == '0 ? 6'(noc) : '0;
      b_pend   <= b_en;
      bias_r   <= b_pend ? b_data : bias_r;
      acc      <= st == MAC ? (ic == '0 ? '0 : acc_f) : st == DRAIN ? acc_f : acc;
      out_we   <= ns == WRITE;
      out_addr <= ns == WRITE ? 16'(int'(oc) * NPIX + int'(pix)) : '0;
      out_data <= ns == WRITE ? clamp_v : '0;
    end
  end
endmodule

// File: tb/tb_pointwise_conv.sv
// tb_pointwise_conv: random and directed passes of a 2x2x2x2 layer checked cycle by cycle against a behavioural model.
module tb_pointwise_conv;
  localparam int IC = 2, OC = 2, H = 2, W = 2, NPIX = H * W;
  localparam int T = OC * NPIX * (IC + 2);
  logic clk = 1'b0, rst_n, start;
  logic busy, done, in_en, w_en, b_en, out_we;
  logic [17:0] in_addr;
  logic [13:0] w_addr;
  logic [5:0] b_addr;
  logic [15:0] out_addr, out_data;
  logic signed [15:0] in_data, b_data;
  logic signed [7:0] w_data;
  logic busy2, done2, in_en2, w_en2, b_en2, out_we2;
  logic [17:0] in_addr2;
  logic [13:0] w_addr2;
  logic [5:0] b_addr2;
  logic [15:0] out_addr2, out_data2;
  logic signed [15:0] in_data2, b_data2;
  logic signed [7:0] w_data2;
  logic signed [15:0] inm [IC*NPIX];
  logic signed [7:0] wm [OC*IC];
  logic signed [15:0] bm [OC];
  int tests = 0, fails = 0;
  int t = 0, nwr = 0, done_cyc = -1, first_wr = -1;
  logic mbusy = 1'b0;

  always #5 clk = ~clk;

  pointwise_conv #(.IN_CHANNELS(IC), .OUT_CHANNELS(OC), .HEIGHT(H), .WIDTH(W), .SHIFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_en(in_en), .in_addr(in_addr), .in_data(in_data),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .b_en(b_en), .b_addr(b_addr), .b_data(b_data),
    .out_we(out_we), .out_addr(out_addr), .out_data(out_data));

  pointwise_conv #(.IN_CHANNELS(IC), .OUT_CHANNELS(OC), .HEIGHT(H), .WIDTH(W), .SHIFT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy2), .done(done2),
    .in_en(in_en2), .in_addr(in_addr2), .in_data(in_data2),
    .w_en(w_en2), .w_addr(w_addr2), .w_data(w_data2),
    .b_en(b_en2), .b_addr(b_addr2), .b_data(b_data2),
    .out_we(out_we2), .out_addr(out_addr2), .out_data(out_data2));

  always @(posedge clk) begin
    if (in_en) in_data <= inm[in_addr[2:0]];
    if (w_en) w_data <= wm[w_addr[1:0]];
    if (b_en) b_data <= bm[b_addr[0]];
    if (in_en2) in_data2 <= inm[in_addr2[2:0]];
    if (w_en2) w_data2 <= wm[w_addr2[1:0]];
    if (b_en2) b_data2 <= bm[b_addr2[0]];
  end

  // pass timeline: t counts cycles since the start-sampling cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mbusy = 1'b0;
      t = 0;
    end else if (mbusy) begin
      if (t == T + 1) begin
        mbusy = 1'b0;
        t = 0;
      end else t = t + 1;
    end else if (start) begin
      mbusy = 1'b1;
      t = 1;
    end
  end

  function automatic int exp_val(input int p, input int sh);
    int oc, px, acc, v;
    oc = p / NPIX;
    px = p % NPIX;
    acc = 0;
    for (int i = 0; i < IC; i++) acc += int'(inm[i*NPIX+px]) * int'(wm[oc*IC+i]);
    v = (acc >>> sh) + int'(bm[oc]);
    return v < 0 ? 0 : v > 32767 ? 32767 : v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0d, time %0t)", nm, act, exp, t, $time);
    end
  endtask

  task automatic compare_cycle();
    int p, ph;
    logic mac, wr, dn;
    p = 0;
    ph = 0;
    mac = 1'b0;
    wr = 1'b0;
    if (!rst_n) return;
    if (mbusy && t == 1) begin
      nwr = 0;
      done_cyc = -1;
      first_wr = -1;
    end
    if (mbusy && t <= T) begin
      p = (t - 1) / (IC + 2);
      ph = (t - 1) % (IC + 2);
      mac = ph < IC;
      wr = ph == IC + 1;
    end
    dn = mbusy && t == T + 1;
    chk("busy", int'(busy), int'(mbusy));
    chk("busy2", int'(busy2), int'(mbusy));
    chk("done", int'(done), int'(dn));
    chk("in_en", int'(in_en), int'(mac));
    chk("w_en", int'(w_en), int'(mac));
    chk("b_en", int'(b_en), int'(mac && ph == 0));
    chk("out_we", int'(out_we), int'(wr));
    chk("out_we2", int'(out_we2), int'(wr));
    if (mac) begin
      chk("in_addr", int'(in_addr), ph * NPIX + p % NPIX);
      chk("w_addr", int'(w_addr), (p / NPIX) * IC + ph);
      if (ph == 0) chk("b_addr", int'(b_addr), p / NPIX);
    end
    if (wr) begin
      chk("out_addr", int'(out_addr), p);
      chk("out_data", int'(out_data), exp_val(p, 0));
      chk("out_addr2", int'(out_addr2), p);
      chk("out_data2", int'(out_data2), exp_val(p, 2));
    end
    if (out_we) begin
      if (first_wr < 0) first_wr = t;
      nwr++;
    end
    if (done) done_cyc = t;
  endtask

  task automatic set_mem(input int iv, input int wv, input int bv);
    foreach (inm[i]) inm[i] = 16'(iv);
    foreach (wm[i]) wm[i] = 8'(wv);
    foreach (bm[i]) bm[i] = 16'(bv);
  endtask

  task automatic run(input int s1, input int s2, input int rst_at);
    bit ended;
    ended = 0;
    @(negedge clk);
    compare_cycle();
    start = 1'b1;
    for (int c = 1; c < 200 && !ended; c++) begin
      @(negedge clk);
      compare_cycle();
      start = (c == s1 || c == s2);
      if (c == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_we", int'(out_we), 0);
        chk("rst_in_en", int'(in_en), 0);
        chk("rst_out_addr", int'(out_addr), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        return;
      end
      if (!mbusy) ended = 1;
    end
    if (!ended) chk("timeout", 0, 1);
    chk("done_cycle", done_cyc, T + 1);
    chk("write_count", nwr, OC * NPIX);
    chk("first_write_cycle", first_wr, IC + 2);
  endtask

  initial begin
    start = 1'b0;
    rst_n = 1'b1;
    set_mem(0, 0, 0);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_en", int'({in_en, w_en, b_en, out_we}), 0);
    chk("reset_addr", int'(in_addr) + int'(w_addr) + int'(b_addr) + int'(out_addr), 0);
    chk("reset_out_data", int'(out_data), 0);
    #2 rst_n = 1'b1;
    set_mem(1, 1, 0);
    chk("model_basic", exp_val(5, 0), 2);
    run(-1, -1, -1);
    set_mem(5, -3, 4);
    chk("model_relu", exp_val(3, 0), 0);
    run(-1, -1, -1);
    set_mem(32767, 127, 100);
    chk("model_sat", exp_val(6, 0), 32767);
    chk("model_sat_sh2", exp_val(1, 2), 32767);
    run(-1, -1, -1);
    set_mem(7, 3, -1);
    chk("model_shift2", exp_val(4, 2), 9);
    chk("model_shift0", exp_val(2, 0), 41);
    run(-1, -1, -1);
    set_mem(1, 1, 0);
    run(5, 20, -1);
    run(-1, -1, 12);
    run(-1, -1, -1);
    for (int k = 0; k < 6; k++) begin
      foreach (inm[i]) inm[i] = 16'($urandom);
      foreach (wm[i]) wm[i] = 8'($urandom);
      foreach (bm[i]) bm[i] = 16'($urandom);
      run(-1, -1, -1);
    end
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pointwise_conv.md
POINTWISE_CONV -- requirements
Module: pointwise_conv

Interface
REQ-001 SHALL have parameter IN_CHANNELS, default 192, meaning input channels (depthwise output channels).
REQ-002 SHALL have parameter OUT_CHANNELS, default 64, meaning output channels.
REQ-003 SHALL have parameter HEIGHT, default 28, and WIDTH, default 32, meaning feature-map size; NPIX = HEIGHT*WIDTH.
REQ-004 SHALL have parameter SHIFT, default 8, meaning arithmetic right shift applied to the accumulator.
REQ-005 SHALL have port clk  input  1  clock; rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have start  input  1  pulse that begins one full-layer pass.
REQ-007 SHALL have busy  output  1  high in every state except IDLE; done  output  1  one-cycle completion pulse.
REQ-008 SHALL have in_en  output  1, in_addr  output  18, in_data  input  16 signed: depthwise-output memory read port, 1-cycle read latency.
REQ-009 SHALL have w_en  output  1, w_addr  output  14, w_data  input  8 signed: weight memory read port, 1-cycle latency.
REQ-010 SHALL have b_en  output  1, b_addr  output  6, b_data  input  16 signed: bias memory read port, 1-cycle latency.
REQ-011 SHALL have out_we  output  1, out_addr  output  16, out_data  output  16: output memory write port.

Function
REQ-012 SHALL implement FSM states IDLE, MAC, DRAIN, WRITE, DONE.
REQ-013 IDLE->MAC when start=1; start ignored in all other states.
REQ-014 Loop order: oc outer (0..OUT_CHANNELS-1), pix middle (0..NPIX-1), ic inner (0..IN_CHANNELS-1).
REQ-015 MAC: one read per cycle, in_en=w_en=1, in_addr = ic*NPIX + pix, w_addr = oc*IN_CHANNELS + ic; ic increments; at ic=IN_CHANNELS-1 -> DRAIN.
REQ-016 In the first MAC cycle of each pixel, b_en=1, b_addr=oc; b_data is held in a register.
REQ-017 Accumulator SHALL be 32-bit signed, cleared at the start of each pixel; in the cycle after each read it adds signed(in_data)*signed(w_data).
REQ-018 DRAIN SHALL accumulate the last product and then -> WRITE.
REQ-019 WRITE: out_we=1, out_addr = oc*NPIX + pix, out_data = clamp((acc >>> SHIFT) + sign-extended bias, 0, 32767), i.e. ReLU then saturation.
REQ-020 After WRITE: advance pix (wrap to 0, increment oc); -> MAC, or -> DONE if oc=OUT_CHANNELS-1 and pix=NPIX-1.
REQ-021 DONE: done=1 for exactly one cycle, then -> IDLE.
REQ-022 Each output pixel SHALL take exactly IN_CHANNELS+2 cycles.
REQ-023 With the start-sampling cycle as cycle 0, done SHALL be high in cycle OUT_CHANNELS*NPIX*(IN_CHANNELS+2)+1.
REQ-024 in_en, w_en, b_en and out_we SHALL be 0 outside the states that drive them.
REQ-025 Intermediate sums SHALL NOT wrap at default parameters: 24-bit products plus 8 bits of channel growth fit in 32 bits.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE and set busy, done, in_en, w_en, b_en and out_we to 0, all addresses to 0, out_data to 0, and all counters and the accumulator to 0.
REQ-027 Reset mid-pass SHALL abort the pass with no further write; a new start after release SHALL restart at oc=0, pix=0.

Verification (IN_CHANNELS=2, OUT_CHANNELS=2, HEIGHT=2, WIDTH=2, SHIFT=0 unless stated)
REQ-028 Basic pass: all in_data=1, w_data=1, bias=0 -> 8 writes of value 2 at out_addr 0..7 in order; done high in cycle 33.
REQ-029 ReLU: in_data=5, w_data=-3, bias=4 -> every out_data=0 (-30+4 clamped).
REQ-030 Saturation: in_data=32767, w_data=127, bias=100 -> every out_data=32767.
REQ-031 Shift: SHIFT=2, in_data=7, w_data=3, bias=-1 -> (42>>>2)-1 = 9 written everywhere.
REQ-032 Start while busy: pulse start at cycles 5 and 20 -> no restart; address sequence and done cycle 33 unchanged.
REQ-033 Reset at cycle 12 -> busy=0 and out_we=0 in the same cycle; start after release -> first write at out_addr 0 in cycle 4.
